// File: rtl/data_mem_resp.sv
// Data-memory responder for a single-cycle core: combinational-read word RAM plus an
// MMIO block with a console TX FIFO, a free-running timer and a compare interrupt.
module data_mem_resp #(
  parameter int          ADDR_BITWIDTH = 10,
  parameter int          WORD_BITWIDTH = 32,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] MMIO_TAG      = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_ce_i,
  input  logic                     data_we_i,
  input  logic [31:0]              data_addr_i,
  input  logic [WORD_BITWIDTH-1:0] data_i,
  output logic [WORD_BITWIDTH-1:0] data_o,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i,
  output logic                     timer_irq_o
);

  localparam int W     = WORD_BITWIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [W-1:0]     ram [0:(2**ADDR_BITWIDTH)-1];
  logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];
  logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
  logic             ovf_reg;
  logic [W-1:0]     counter_reg, cmp_reg;
  logic             irq_reg;

  logic                     is_mmio, store;
  logic [13:0]              mmio_word;
  logic [ADDR_BITWIDTH-1:0] ram_idx;
  logic                     sel_tx, sel_status, sel_timer, sel_cmp;
  logic                     fifo_empty, fifo_full;
  logic                     pop, push_req, push_ok, push_drop, ovf_clear;
  logic                     unused_addr_lsbs;

  assign is_mmio          = (data_addr_i[31:16] == MMIO_TAG);
  assign mmio_word        = data_addr_i[15:2];
  assign ram_idx          = data_addr_i[ADDR_BITWIDTH+1:2];
  assign store            = data_ce_i & data_we_i;
  assign unused_addr_lsbs = ^data_addr_i[1:0];

  assign sel_tx     = (mmio_word == 14'd0);
  assign sel_status = (mmio_word == 14'd1);
  assign sel_timer  = (mmio_word == 14'd2);
  assign sel_cmp    = (mmio_word == 14'd3);

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  assign pop       = ~fifo_empty & tx_ready_i;
  assign push_req  = store & is_mmio & sel_tx;
  assign push_ok   = push_req & (~fifo_full | pop);
  assign push_drop = push_req & fifo_full & ~pop;
  assign ovf_clear = store & is_mmio & sel_status & data_i[2];

  assign tx_valid_o  = ~fifo_empty;
  assign tx_data_o   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg[PTR_W-1:0]];
  assign timer_irq_o = irq_reg;

  always_comb begin
    data_o = '0;
    if (data_ce_i && !data_we_i) begin
      if (!is_mmio) begin
        data_o = ram[ram_idx];
      end else begin
        case (mmio_word)
          14'd1:   data_o = {{(W-3){1'b0}}, ovf_reg, fifo_full, fifo_empty};
          14'd2:   data_o = counter_reg;
          14'd3:   data_o = cmp_reg;
          default: data_o = '0;
        endcase
      end
    end
  end

  // RAM content is deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (store && !is_mmio) ram[ram_idx] <= data_i;
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
      always_ff @(posedge clk) begin
        if (push_ok && rst && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi)))
          fifo_mem[gi] <= data_i[7:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      ovf_reg     <= 1'b0;
      counter_reg <= '0;
      cmp_reg     <= '1;
      irq_reg     <= 1'b0;
    end else begin
      if (pop)     rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      // A dropped push in the same cycle as a clear leaves overflow set.
      if (push_drop)      ovf_reg <= 1'b1;
      else if (ovf_clear) ovf_reg <= 1'b0;
      if (store && is_mmio && sel_timer) counter_reg <= data_i;
      else                               counter_reg <= counter_reg + W'(1);
      if (store && is_mmio && sel_cmp) cmp_reg <= data_i;
      irq_reg <= (counter_reg >= cmp_reg);
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized and directed bench for data_mem_resp, checked against a queue/array model.
module tb_data_mem_resp;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_TX = 32'hFFFF0000, A_ST = 32'hFFFF0004,
                          A_TM = 32'hFFFF0008, A_CMP = 32'hFFFF000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_ce_i = 1'b0, data_we_i = 1'b0, tx_ready_i = 1'b0;
  logic [31:0] data_addr_i = '0, data_i = '0;
  logic [31:0] data_o;
  logic        tx_valid_o, timer_irq_o;
  logic [7:0]  tx_data_o;

  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_BITWIDTH(10), .WORD_BITWIDTH(32), .FIFO_DEPTH(DEPTH),
                  .MMIO_TAG(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .data_ce_i(data_ce_i), .data_we_i(data_we_i),
    .data_addr_i(data_addr_i), .data_i(data_i), .data_o(data_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .timer_irq_o(timer_irq_o));

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram_m [0:1023];
  logic [7:0]  q[$];
  logic        ovf_m, irq_m;
  logic [31:0] cnt_m, cmp_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic ce, input logic we, input logic [31:0] a);
    logic [15:0] off;
    off = {a[15:2], 2'b00};
    if (!ce || we) return 32'h0;
    if (a[31:16] != 16'hFFFF) return ram_m[a[11:2]];
    case (off)
      16'h0004: return {29'b0, ovf_m, q.size() == DEPTH, q.size() == 0};
      16'h0008: return cnt_m;
      16'h000C: return cmp_m;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic ce, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic rdy);
    logic mm, wr, pop, full;
    logic [15:0] off;
    mm   = (a[31:16] == 16'hFFFF);
    off  = {a[15:2], 2'b00};
    wr   = ce && we;
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == DEPTH);
    irq_m = (cnt_m >= cmp_m);
    if (pop) void'(q.pop_front());
    if (wr && mm && off == 16'h0000) begin
      if (!full || pop) q.push_back(d[7:0]);
      else ovf_m = 1'b1;
    end else if (wr && mm && off == 16'h0004 && d[2]) begin
      ovf_m = 1'b0;
    end
    if (wr && mm && off == 16'h0008) cnt_m = d;
    else cnt_m = cnt_m + 32'd1;
    if (wr && mm && off == 16'h000C) cmp_m = d;
    if (wr && !mm) ram_m[a[11:2]] = d;
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0; irq_m = 1'b0; cnt_m = '0; cmp_m = '1;
  endtask

  task automatic cyc(input logic ce, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy);
    @(negedge clk);
    data_ce_i = ce; data_we_i = we; data_addr_i = a; data_i = d; tx_ready_i = rdy;
    #1;
    $display("cyc ce=%0b we=%0b addr=%h data=%h rdy=%0b -> data_o=%h txv=%0b txd=%h irq=%0b",
             ce, we, a, d, rdy, data_o, tx_valid_o, tx_data_o, timer_irq_o);
    check_val("data_o", data_o, model_read(ce, we, a));
    check_val("tx_valid", 32'(tx_valid_o), 32'(q.size() != 0));
    check_val("tx_data", 32'(tx_data_o), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check_val("timer_irq", 32'(timer_irq_o), 32'(irq_m));
    model_edge(ce, we, a, d, rdy);
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cyc(1'b1, 1'b0, a, 32'h0, 1'b0);
    check_val(tag, data_o, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    $display("reset asserted");
    check_val("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    check_val("rst_tx_data", 32'(tx_data_o), 32'h0);
    check_val("rst_irq", 32'(timer_irq_o), 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic drain_expect(input string bytes_exp);
    for (int i = 0; i < bytes_exp.len(); i++) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check_val("drain_order", 32'(tx_data_o), 32'(bytes_exp[i]));
    end
  endtask

  initial begin
    string s;
    logic [31:0] a, d;
    logic ce, we, rdy;
    int op;
    bit seen;

    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    check_val("init_tx_valid", 32'(tx_valid_o), 32'h0);
    check_val("init_irq", 32'(timer_irq_o), 32'h0);

    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // RAM store, load, alias, disabled load
    cyc(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
    rd_expect("ram_load", 32'h40, 32'hDEADBEEF);
    rd_expect("ram_alias", 32'h1040, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
    check_val("ce0_load", data_o, 32'h0);

    // FIFO fill, overflow, drain, clear
    rd_expect("status_empty", A_ST, 32'h1);
    s = "ABCDE";
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, A_TX, 32'(s[i]), 1'b0);
    rd_expect("status_full", A_ST, 32'h2);
    cyc(1'b1, 1'b1, A_TX, 32'(s[4]), 1'b0);
    rd_expect("status_ovf", A_ST, 32'h6);
    drain_expect("ABCD");
    rd_expect("status_drained", A_ST, 32'h5);
    cyc(1'b1, 1'b1, A_ST, 32'h4, 1'b0);
    rd_expect("status_cleared", A_ST, 32'h1);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, A_TX, 32'(s[i]), 1'b0);
    cyc(1'b1, 1'b1, A_TX, 32'h58, 1'b1);
    rd_expect("status_full_no_ovf", A_ST, 32'h2);
    drain_expect("BCDX");

    // Timer wrap
    cyc(1'b1, 1'b1, A_TM, 32'hFFFFFFFE, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rd_expect("timer_wrap", A_TM, 32'h0);

    // Compare interrupt timing after reset
    do_reset();
    cyc(1'b1, 1'b1, A_CMP, 32'd10, 1'b0);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc(1'b1, 1'b0, A_TM, 32'h0, 1'b0);
      if (data_o == 32'd10) begin
        seen = 1;
        check_val("irq_at_hit", 32'(timer_irq_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check_val("irq_after_hit", 32'(timer_irq_o), 32'h1);
      end
    end
    check_val("timer_reached_10", 32'(seen), 32'h1);

    // Unmapped MMIO
    cyc(1'b1, 1'b1, 32'hFFFF0020, 32'h1234, 1'b0);
    rd_expect("unmapped_read", 32'hFFFF0020, 32'h0);
    rd_expect("unmapped_no_fifo", A_ST, 32'h1);

    // Reset mid-operation
    cyc(1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, A_TX, 32'(s[i]), 1'b0);
    cyc(1'b1, 1'b1, A_TM, 32'd500, 1'b0);
    @(negedge clk);
    data_ce_i = 1'b1; data_we_i = 1'b1; data_addr_i = A_TX; data_i = 32'h5A;
    do_reset();
    rd_expect("timer_after_rst", A_TM, 32'h0);
    rd_expect("status_after_rst", A_ST, 32'h1);
    rd_expect("ram_kept", 32'h80, 32'hCAFEF00D);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 10);
      d = $urandom; ce = 1'b1; we = 1'b0;
      rdy = ($urandom_range(0, 1) == 1);
      a = {A_TX[31:4], 2'b00, 2'($urandom)};
      case (op)
        0, 1: begin
          a = $urandom;
          a[31:16] = 16'($urandom_range(0, 65534));
          a[11:2] = 10'($urandom_range(0, 15));
          we = (op == 1);
        end
        2: we = 1'b1;
        3: a[3:2] = 2'd1;
        4: begin a[3:2] = 2'd1; we = 1'b1; end
        5: a[3:2] = 2'd2;
        6: begin a[3:2] = 2'd2; we = 1'b1; d = $urandom_range(0, 60); end
        7: begin a[3:2] = 2'd3; we = 1'b1; d = $urandom_range(0, 60); end
        8: a[3:2] = 2'd3;
        9: begin ce = 1'b0; we = 1'($urandom); a = $urandom; end
        default: begin a = {16'hFFFF, 16'($urandom_range(16, 65535))}; we = 1'($urandom); end
      endcase
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(ce, we, a, d, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
